// File: rtl/div_issue_if.sv
// Request/result handshake bundle between controller logic and the divide issue stage.
// Master drives requests and accepts results; slave is the issue stage.
interface div_issue_if #(
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_lop;
   logic [7:0]       in_rop;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_quot;
   logic [7:0]       out_mod;
   logic [TAG_W-1:0] out_tag;
   logic             out_dbz;

   modport master (
      output in_valid, in_lop, in_rop, in_tag, out_ready,
      input  in_ready, out_valid, out_quot, out_mod, out_tag, out_dbz
   );

   modport slave (
      input  in_valid, in_lop, in_rop, in_tag, out_ready,
      output in_ready, out_valid, out_quot, out_mod, out_tag, out_dbz
   );
endinterface

// File: rtl/div_issue_stage.sv
// Request FIFO in front of a combinational 8-bit divider with a registered,
// tagged result, divide-by-zero interception and a saturating error count.
module div_issue_stage #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   div_issue_if.slave               bus,
   output logic [7:0]               div_lop,
   output logic [7:0]               div_rop,
   input  logic [7:0]               div_quot,
   input  logic [7:0]               div_mod,
   output logic [7:0]               dbz_count,
   output logic [$clog2(DEPTH):0]   occupancy
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   logic [7:0]       lop_q [DEPTH];
   logic [7:0]       rop_q [DEPTH];
   logic [TAG_W-1:0] tag_q [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             push;
   logic             issue;
   logic             nonempty;
   logic [7:0]       head_lop;
   logic [7:0]       head_rop;
   logic [TAG_W-1:0] head_tag;

   assign nonempty    = (occupancy != '0);
   assign bus.in_ready = (occupancy != FULL);
   assign push        = bus.in_valid && bus.in_ready;
   assign issue       = nonempty && (!bus.out_valid || bus.out_ready);

   assign head_lop = lop_q[rd_ptr];
   assign head_rop = rop_q[rd_ptr];
   assign head_tag = tag_q[rd_ptr];

   assign div_lop = nonempty ? head_lop : 8'h00;
   assign div_rop = nonempty ? head_rop : 8'h00;

   always_ff @(posedge clk) begin
      if (push) begin
         lop_q[wr_ptr] <= bus.in_lop;
         rop_q[wr_ptr] <= bus.in_rop;
         tag_q[wr_ptr] <= bus.in_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         occupancy     <= '0;
         bus.out_valid <= 1'b0;
         bus.out_quot  <= 8'h00;
         bus.out_mod   <= 8'h00;
         bus.out_tag   <= '0;
         bus.out_dbz   <= 1'b0;
         dbz_count     <= 8'h00;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (issue)
            rd_ptr <= rd_ptr + PW'(1);

         case ({push, issue})
            2'b10:   occupancy <= occupancy + 1'b1;
            2'b01:   occupancy <= occupancy - 1'b1;
            default: occupancy <= occupancy;
         endcase

         // zero divisor: divider output is ignored, quotient forced to all-ones
         if (issue) begin
            bus.out_valid <= 1'b1;
            bus.out_tag   <= head_tag;
            if (head_rop == 8'h00) begin
               bus.out_quot <= 8'hFF;
               bus.out_mod  <= head_lop;
               bus.out_dbz  <= 1'b1;
               if (dbz_count != 8'hFF)
                  dbz_count <= dbz_count + 8'd1;
            end else begin
               bus.out_quot <= div_quot;
               bus.out_mod  <= div_mod;
               bus.out_dbz  <= 1'b0;
            end
         end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: doc/div_issue_stage.md
Name: div_issue_stage

Overview:
- Sequential front end for the 8-bit combinational divider. Buffers divide requests in a small FIFO, presents one request per cycle to the divider's lop/rop inputs, and captures the divider's quot/mod into a registered, tagged result with a valid/ready handshake.
- Also intercepts divide-by-zero and counts those errors.
- Sits between the requesting controller logic (upstream) and the divider (downstream, purely combinational, zero latency).

Parameters:
- DEPTH, 4, request FIFO entries; power of two, 2..16
- TAG_W, 4, width of the request tag carried alongside each operation

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  FIFO can accept a request
- in_lop  in  8  dividend
- in_rop  in  8  divisor
- in_tag  in  TAG_W  request tag
- div_lop  out  8  dividend driven to the divider
- div_rop  out  8  divisor driven to the divider
- div_quot  in  8  quotient returned by the divider, same cycle
- div_mod  in  8  remainder returned by the divider, same cycle
- out_valid  out  1  result register holds a result
- out_ready  in  1  consumer accepts the result
- out_quot  out  8  quotient
- out_mod  out  8  remainder
- out_tag  out  TAG_W  tag of the result
- out_dbz  out  1  result came from a zero divisor
- dbz_count  out  8  saturating count of divide-by-zero results issued
- occupancy  out  $clog2(DEPTH)+1  current FIFO entry count

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - FIFO empty, rd/wr pointers 0, occupancy 0.
  - out_valid 0; out_quot, out_mod, out_tag, out_dbz all 0.
  - dbz_count 0.
  - Reset mid-operation discards all queued and held results; no partial output.
- FIFO and input handshake:
  - in_ready = (occupancy != DEPTH). It is not combinationally dependent on a same-cycle pop, so a full FIFO refuses input even while a pop occurs.
  - Push when in_valid && in_ready.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Divider drive:
  - div_lop/div_rop = FIFO head entry whenever the FIFO is non-empty, otherwise 0.
  - Purely combinational from the head registers; no other logic drives them.
- Issue:
  - issue = (occupancy != 0) && (!out_valid || out_ready).
  - On issue, at the clock edge the head is popped and the result register loads:
    - rop != 0: out_quot = div_quot, out_mod = div_mod, out_dbz = 0.
    - rop == 0: out_quot = 8'hFF, out_mod = head lop, out_dbz = 1. div_quot/div_mod are ignored.
    - out_tag = head tag; out_valid = 1.
  - If out_valid && out_ready && !issue, out_valid clears.
  - The result register holds stable while out_valid && !out_ready.
- Occupancy:
  - +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - Simultaneous push and pop on the empty-to-nonempty boundary is impossible, because pop requires a non-empty FIFO.
- Latency and throughput:
  - A request accepted at edge N is issued at edge N+1 at the earliest; out_valid is high in the cycle after edge N+1.
  - There is no input-to-output bypass.
  - Sustained throughput is 1 result/cycle with out_ready held high.
- dbz_count increments on every issue with rop==0 and saturates at 8'hFF.
- Ordering: results leave in strict acceptance order; tags are never reordered.
- Widths: all arithmetic is unsigned; occupancy is the only counter wider than its pointer.

Test Plan:
- Reset, then push (lop=200, rop=7, tag=3) with out_ready=1 -> out_valid is high two cycles after acceptance, with quot=28, mod=4, tag=3, dbz=0.
- Push (lop=0x55, rop=0, tag=9) -> quot=0xFF, mod=0x55, dbz=1, dbz_count=1; push 300 more zero-divisor requests -> dbz_count holds at 0xFF.
- Hold out_ready=0 and push 5 requests with DEPTH=4 -> one result held in the output register, FIFO full at 4, in_ready=0, and the 6th push is refused; release out_ready -> results drain in tag order 0..4 at one per cycle.
- Continuous in_valid and out_ready for 20 requests -> in_ready stays 1, occupancy stays at or below 1, output is back-to-back every cycle, and pointers wrap correctly.
- Assert reset with 3 queued and 1 held result -> on the next cycle out_valid=0, occupancy=0, dbz_count=0, in_ready=1.
- Randomised lop/rop in 0..255 with random out_ready -> every result matches lop/rop and lop%rop (or the divide-by-zero rule), and tags stay in order.
